// File: rtl/alu_issue_if.sv
// Bundles the upstream instruction handshake, the control/status lines and the
// decoded issue bus that feeds the ALU pipeline. The slave side is the issue
// stage itself; the master side is whoever drives instructions and consumes issues.
interface alu_issue_if;
  // Upstream instruction handshake
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_instr;

  // HALT control and status
  logic        resume;
  logic        halted;
  logic [7:0]  illegal_cnt;

  // Decoded issue bus towards the ALU pipeline
  logic        issue_valid;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [3:0]  rd;
  logic [3:0]  func;
  logic [7:0]  addr;

  modport master (
    output in_valid, in_instr, resume,
    input  in_ready, halted, illegal_cnt,
    input  issue_valid, rs1, rs2, rd, func, addr
  );

  modport slave (
    input  in_valid, in_instr, resume,
    output in_ready, halted, illegal_cnt,
    output issue_valid, rs1, rs2, rd, func, addr
  );
endinterface

// File: rtl/alu_issue.sv
// Issue stage: buffers 24-bit instructions, stalls on RAW hazards, drops illegal ops, parks on HALT.
// Latency: push at edge k into an empty hazard-free FIFO issues at edge k+1 (no bypass).
// Backpressure: in_ready = count < DEPTH; no push while full even if the head pops that cycle.
module alu_issue #(
  parameter int DEPTH   = 4,
  parameter int HAZ_WIN = 2
) (
  input logic      clk1,
  input logic      rst_n,
  alu_issue_if.slave io
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [3:0] func;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic [7:0] addr;
  } instr_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // Instruction FIFO
  instr_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  instr_t        head;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  // Scoreboard of recently issued destinations; slot 0 is the newest
  logic [HAZ_WIN-1:0] sb_v_q;
  logic [3:0]         sb_rd_q [HAZ_WIN];

  // Head decode and issue decisions
  logic use_rs1;
  logic use_rs2;
  logic is_illegal;
  logic is_halt;
  logic hazard;
  logic do_issue;
  logic do_drop;

  // Registered outputs
  logic       issue_valid_q;
  instr_t     issue_q;
  logic [7:0] illegal_cnt_q;

  assign head       = mem[rd_ptr_q];
  assign fifo_empty = (cnt_q == '0);
  assign io.in_ready = (cnt_q < FULL_CNT);
  assign push       = io.in_valid && io.in_ready;

  // Classify the head opcode by which sources it reads
  always_comb begin
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    is_illegal = 1'b0;
    is_halt    = 1'b0;
    case (head.func)
      4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      4'd3, 4'd8, 4'd10, 4'd11: use_rs1 = 1'b1;
      4'd4, 4'd9:               use_rs2 = 1'b1;
      4'd15:                    is_halt = 1'b1;
      default:                  is_illegal = 1'b1;
    endcase
  end

  // A used source matching any in-flight destination blocks the head
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++) begin
      if (sb_v_q[i] && ((use_rs1 && (head.rs1 == sb_rd_q[i])) ||
                        (use_rs2 && (head.rs2 == sb_rd_q[i])))) begin
        hazard = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a popped HALT parks the block until resume is sampled
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (!fifo_empty && is_halt) state_d = ST_HALT;
      ST_HALT: if (io.resume)              state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // FSM outputs: HALT and illegal heads pop regardless of hazards; legal heads pop only when clear
  always_comb begin
    pop      = 1'b0;
    do_issue = 1'b0;
    do_drop  = 1'b0;
    if ((state_q == ST_RUN) && !fifo_empty) begin
      if (is_halt) begin
        pop = 1'b1;
      end else if (is_illegal) begin
        pop     = 1'b1;
        do_drop = 1'b1;
      end else if (!hazard) begin
        pop      = 1'b1;
        do_issue = 1'b1;
      end
    end
  end

  // FIFO storage is not reset; the count qualifies every read
  always_ff @(posedge clk1) begin
    if (push) begin
      mem[wr_ptr_q] <= io.in_instr;
    end
  end

  // FIFO pointers wrap naturally at DEPTH; count tracks occupancy 0..DEPTH
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Scoreboard shifts every cycle: the issued rd or a bubble enters, the oldest slot falls off
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      sb_v_q <= '0;
      for (int i = 0; i < HAZ_WIN; i++) begin
        sb_rd_q[i] <= '0;
      end
    end else begin
      sb_v_q[0]  <= do_issue;
      sb_rd_q[0] <= do_issue ? head.rd : 4'd0;
      for (int i = 1; i < HAZ_WIN; i++) begin
        sb_v_q[i]  <= sb_v_q[i-1];
        sb_rd_q[i] <= sb_rd_q[i-1];
      end
    end
  end

  // Issue register: fields hold their last issued values between issues
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_q <= 1'b0;
      issue_q       <= '0;
    end else begin
      issue_valid_q <= do_issue;
      if (do_issue) begin
        issue_q <= head;
      end
    end
  end

  // Dropped-illegal counter saturates instead of wrapping
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt_q <= '0;
    end else if (do_drop && (illegal_cnt_q != 8'hFF)) begin
      illegal_cnt_q <= illegal_cnt_q + 8'd1;
    end
  end

  assign io.issue_valid = issue_valid_q;
  assign io.func        = issue_q.func;
  assign io.rs1         = issue_q.rs1;
  assign io.rs2         = issue_q.rs2;
  assign io.rd          = issue_q.rd;
  assign io.addr        = issue_q.addr;
  assign io.illegal_cnt = illegal_cnt_q;
  assign io.halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: expected issues are queued as words are pushed
// and compared field-for-field when issue_valid is seen; issue edges are logged for timing checks.
module tb_alu_issue;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [23:0] exp_q[$];
  int          issue_times[$];

  alu_issue_if ifc ();

  alu_issue #(.DEPTH(4), .HAZ_WIN(2)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .io    (ifc)
  );

  always #5 clk1 = ~clk1;

  // Edge counter: after posedge n (and at the following negedge) cyc == n
  always @(posedge clk1) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Issue monitor: every issue must match the oldest outstanding expectation
  always @(negedge clk1) begin
    if (rst_n && ifc.issue_valid) begin
      logic [23:0] obs;
      obs = {ifc.func, ifc.rs1, ifc.rs2, ifc.rd, ifc.addr};
      issue_times.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_issue: observed %06h expected none", obs);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        assert (obs === e) else begin
          errors++;
          $error("FAIL issue_fields: observed %06h expected %06h", obs, e);
        end
      end
    end
  end

  // One-cycle push; only plain ALU ops (func < 12) are expected downstream
  task automatic push_word(input logic [23:0] w);
    ifc.in_valid = 1'b1;
    ifc.in_instr = w;
    chk("push_ready", 32'(ifc.in_ready), 32'd1);
    if (w[23:20] < 4'd12) exp_q.push_back(w);
    @(posedge clk1); #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_issues(input int n, input int budget, input string tag);
    int k = 0;
    while (issue_times.size() < n && k < budget) begin
      @(negedge clk1); #1;
      k++;
    end
    chk(tag, 32'(issue_times.size()), 32'(n));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk1); #1;
    end
  endtask

  task automatic pulse_resume(output int edge_n);
    ifc.resume = 1'b1;
    @(posedge clk1); #1;
    edge_n = cyc;
    ifc.resume = 1'b0;
  endtask

  initial begin
    logic [23:0] fill_w [5];
    int r;
    fill_w[0] = 24'h023110;
    fill_w[1] = 24'h045611;
    fill_w[2] = 24'h578912;
    fill_w[3] = 24'h2ABC13;
    fill_w[4] = 24'h0DEF14;

    ifc.in_valid = 1'b0;
    ifc.in_instr = '0;
    ifc.resume   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk1);
    #1;
    chk("rst_issue_valid", 32'(ifc.issue_valid), 32'd0);
    chk("rst_halted",      32'(ifc.halted),      32'd0);
    chk("rst_fields",      32'({ifc.func, ifc.rs1, ifc.rs2, ifc.rd, ifc.addr}), 32'd0);
    chk("rst_illegal_cnt", 32'(ifc.illegal_cnt), 32'd0);
    rst_n = 1'b1;
    idle(1);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);

    // Independent stream: back-to-back issues
    issue_times.delete();
    push_word(24'h023100);
    push_word(24'h556400);
    wait_issues(2, 10, "indep_count");
    if (issue_times.size() == 2) chk("indep_spacing", 32'(issue_times[1] - issue_times[0]), 32'd1);
    idle(4);

    // RAW stall: consumer of rd=1 issues three edges after producer
    issue_times.delete();
    push_word(24'h023100);
    push_word(24'h114500);
    wait_issues(2, 12, "raw_count");
    if (issue_times.size() == 2) chk("raw_spacing", 32'(issue_times[1] - issue_times[0]), 32'd3);
    idle(4);

    // Unused source: func 9 reads rs2 only, so rs1 == 1 is not a hazard
    issue_times.delete();
    push_word(24'h023100);
    push_word(24'h912700);
    wait_issues(2, 10, "unused_count");
    if (issue_times.size() == 2) chk("unused_spacing", 32'(issue_times[1] - issue_times[0]), 32'd1);
    idle(4);

    // Illegal drop, HALT, held ADD
    issue_times.delete();
    push_word(24'hD00000);
    push_word(24'hF00000);
    push_word(24'h023100);
    idle(4);
    chk("ill_cnt",      32'(ifc.illegal_cnt),      32'd1);
    chk("halt_set",     32'(ifc.halted),           32'd1);
    chk("halt_no_issue",32'(issue_times.size()),   32'd0);
    chk("halt_add_held",32'(exp_q.size()),         32'd1);
    pulse_resume(r);
    chk("resume_halted", 32'(ifc.halted), 32'd0);
    wait_issues(1, 10, "resume_count");
    if (issue_times.size() == 1) chk("resume_issue_edge", 32'(issue_times[0]), 32'(r + 1));
    idle(4);

    // Full FIFO while halted: in_valid held across five words, fifth refused
    issue_times.delete();
    push_word(24'hF00000);
    idle(3);
    chk("full_halted", 32'(ifc.halted), 32'd1);
    for (int i = 0; i < 5; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_instr = fill_w[i];
      chk($sformatf("full_ready_%0d", i), 32'(ifc.in_ready), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) exp_q.push_back(fill_w[i]);
      @(posedge clk1); #1;
    end
    ifc.in_valid = 1'b0;
    chk("full_no_issue", 32'(issue_times.size()), 32'd0);
    pulse_resume(r);
    wait_issues(4, 15, "full_drain_count");
    idle(3);
    chk("full_drain_exact", 32'(issue_times.size()), 32'd4);
    chk("full_ready_back",  32'(ifc.in_ready),       32'd1);
    chk("full_exp_empty",   32'(exp_q.size()),       32'd0);
    idle(2);

    // Reset mid-stall with three entries held
    issue_times.delete();
    push_word(24'h023100);
    push_word(24'h114500);
    push_word(24'h227800);
    push_word(24'h339A00);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mrst_issue_valid", 32'(ifc.issue_valid), 32'd0);
    chk("mrst_fields",      32'({ifc.func, ifc.rs1, ifc.rs2, ifc.rd, ifc.addr}), 32'd0);
    chk("mrst_illegal_cnt", 32'(ifc.illegal_cnt), 32'd0);
    chk("mrst_halted",      32'(ifc.halted),      32'd0);
    @(posedge clk1); #1;
    rst_n = 1'b1;
    issue_times.delete();
    idle(8);
    chk("mrst_quiet",    32'(issue_times.size()), 32'd0);
    chk("mrst_in_ready", 32'(ifc.in_ready),       32'd1);
    push_word(24'h045611);
    wait_issues(1, 10, "mrst_new_issue");
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop if the directed sequence ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue stage sitting directly upstream of the 4-stage ALU pipeline. It accepts 24-bit instruction words over a valid/ready handshake and buffers them in a small FIFO. It issues one decoded instruction per clock as rs1/rs2/rd/func/addr to the ALU pipeline, stalling on read-after-write hazards against results not yet written back to the register bank. It also handles a HALT opcode and drops illegal opcodes, counting them.

## Interface
- DEPTH, 4: instruction FIFO entries; power of two, ≥2.
- HAZ_WIN, 2: number of previously issued instructions whose rd blocks a dependent read.
- clk1  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  FIFO can accept; equals "count < DEPTH".
- in_instr  in  24  {func[23:20], rs1[19:16], rs2[15:12], rd[11:8], addr[7:0]}.
- resume  in  1  single-cycle pulse; leaves HALT.
- issue_valid  out  1  rs1/rs2/rd/func/addr carry a new instruction this cycle.
- rs1, rs2, rd, func  out  4 each  decoded fields to the ALU pipeline (registered).
- addr  out  8  memory write address to the ALU pipeline (registered).
- halted  out  1  block is in HALT.
- illegal_cnt  out  8  count of dropped illegal opcodes; saturates at 255.

## Operation
- Push: in_valid & in_ready at a posedge writes in_instr at the tail. There is no push while full, even if a pop occurs in the same cycle.
- Head decode, by source usage:
  - func 0,1,2,5,6,7 read rs1 and rs2.
  - func 3,8,10,11 read rs1 only.
  - func 4,9 read rs2 only.
  - func 12–14 are illegal.
  - func 15 is HALT.
- Scoreboard: HAZ_WIN slots of {v, rd}. Each posedge shifts in {1, rd} when an instruction issues, otherwise {0, x}. The oldest slot falls off.
- Hazard: a used source of the head equals rd of any valid scoreboard slot. An unused source never causes a hazard.
- States and transitions, all evaluated at posedge:
  - RUN, empty: issue_valid = 0.
  - RUN, head legal, no hazard: pop the head, register its fields onto the outputs, set issue_valid = 1, shift rd into the scoreboard.
  - RUN, head legal, hazard (STALL): no pop, issue_valid = 0, shift a bubble into the scoreboard.
  - RUN, head illegal: pop and drop, issue_valid = 0, illegal_cnt += 1 (saturating), shift a bubble. The drop is not blocked by hazards.
  - RUN, head HALT: pop, issue_valid = 0, go to HALT, shift a bubble. The HALT is not issued downstream.
  - HALT: no pops. Pushes continue while not full. The scoreboard keeps shifting bubbles. resume = 1 returns to RUN at the next posedge; the head may issue at the posedge after that.
- resume while in RUN is ignored.
- Output fields hold their last issued values when issue_valid = 0.
- Reset (asynchronous, any time including mid-stall or in HALT):
  - FIFO emptied (pointers and count 0), scoreboard invalid, state RUN.
  - issue_valid, halted, rs1, rs2, rd, func, addr, illegal_cnt all 0.
  - in_ready = 1 once reset is released.

## Timing
- Accept-to-issue: an instruction pushed at posedge k into an empty, hazard-free FIFO asserts issue_valid after posedge k+1. There is no same-cycle bypass.
- Throughput: one issue per cycle for independent instructions.
- Dependent back-to-back pair with HAZ_WIN = 2: producer issues at edge t; consumer issues at edge t+3, giving two bubble cycles.
- A dependence on the instruction issued two edges earlier costs one bubble.
- halted rises the cycle after the HALT pop and falls the cycle after resume is sampled.
- in_ready deasserts the cycle after the DEPTH-th entry is held. It reasserts the cycle after a pop from full.
- FIFO pointers wrap modulo DEPTH. count ranges 0..DEPTH.

## Test plan
- Independent stream: push ADD r1=r2+r3 (0x023100) and then AND r4=r5&r6 (0x556400) on consecutive cycles. Required: issue_valid high on two consecutive cycles with func 0 then 5 and rd 1 then 4.
- RAW stall: push 0x023100 (rd = 1) and then SUB with rs1 = 1 (0x114500). Required: SUB issues exactly 3 edges after ADD; two issue_valid = 0 cycles between them.
- Unused-source check: after rd = 1, push NOT-b (func 9, rs1 = 1, rs2 = 2). Required: no stall, issues on the next cycle.
- Illegal and halt:
  - Push func 13, then func 15, then an ADD. Required: illegal_cnt = 1, nothing issued for funcs 13 and 15, halted = 1, and the ADD is held.
  - Pulse resume. Required: halted = 0 one cycle later and the ADD issued on the following edge.
- Full FIFO: with the block in HALT, push 5 words while in_valid is held. Required: in_ready = 0 after the 4th accept and the 5th word is not taken. After resume, words 1–4 issue in order.
- Reset mid-stall: assert rst_n = 0 while STALL is active with 3 entries held. Required: all outputs 0 immediately, and after release nothing issues until new pushes arrive.
